// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and the
// interrupt FSM encoding, used by cp0, the decoder and the control unit.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IM_HI    = 15;
  localparam int SR_IM_LO    = 10;
  localparam int SR_EXL      = 1;
  localparam int SR_IE       = 0;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_IP_LO = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } cp0_state_t;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PrID registers, MFC0/MTC0 access and the
// interrupt request FSM that feeds the pipeline flush logic.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4A57_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic        ERET,
  input  logic        Stall,
  input  logic [5:0]  HWInt,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [31:2] epc_q;
  logic        exl_next;
  logic        wr_sr;
  logic        wr_epc;
  logic        int_cond;
  logic        detect;
  cp0_state_t  state;
  cp0_state_t  state_next;

  // EPC is word aligned, so the low PC bits are never stored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^PC[1:0];

  assign wr_sr  = We && (A2 == REG_SR);
  assign wr_epc = We && (A2 == REG_EPC);

  // Uses the registered SR, so an MTC0 in the same cycle cannot mask or
  // unmask the interrupt being evaluated now.
  assign int_cond = (|(HWInt & im_q)) & ie_q & ~exl_q & ~Stall;
  // ERET is handled first; a still-pending interrupt is seen next cycle.
  assign detect   = (state == IDLE) && int_cond && !ERET;

  // NOTE: later assignments override earlier ones, so priority reads top to
  // bottom; the default first keeps this block free of inferred latches.
  always_comb begin
    exl_next = exl_q;
    if (wr_sr)  exl_next = DIn[SR_EXL];
    if (ERET)   exl_next = 1'b0;
    if (detect) exl_next = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      exl_q <= exl_next;
      if (wr_sr) begin
        im_q <= DIn[SR_IM_HI:SR_IM_LO];
        ie_q <= DIn[SR_IE];
      end
      if (detect)      epc_q <= PC[31:2];
      else if (wr_epc) epc_q <= DIn[31:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (detect) state_next = REQ;
      REQ:     state_next = HANDLER;
      HANDLER: if (!exl_next) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign IntReq = (state == REQ);
  assign EPC    = {epc_q, 2'b00};

  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR: begin
        DOut[SR_IM_HI:SR_IM_LO] = im_q;
        DOut[SR_EXL]            = exl_q;
        DOut[SR_IE]             = ie_q;
      end
      REG_CAUSE: DOut[CAUSE_IP_HI:CAUSE_IP_LO] = HWInt;
      REG_EPC:   DOut = {epc_q, 2'b00};
      REG_PRID:  DOut = PRID;
      default:   DOut = '0;
    endcase
  end

endmodule
